// File: rtl/spike_train_monitor_pkg.sv
// Shared definitions for the spike train monitor: Q9.7 potential format,
// FSM state encoding and record width helper.
package spike_train_monitor_pkg;

  localparam int unsigned FRAC_BITS = 7;
  localparam int unsigned V_W       = 16;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_REFRACT    = 2'd1,
    ST_MEASURE    = 2'd2
  } state_t;

  // Packed record width: ISI field followed by the 9.7 membrane potential.
  function automatic int unsigned rec_w(input int unsigned isi_w);
    return isi_w + V_W;
  endfunction

endpackage

// File: rtl/spike_train_monitor_if.sv
// Record stream between the monitor (master) and its consumer (slave).
interface spike_train_monitor_if #(
  parameter int unsigned ISI_W = 16
);
  import spike_train_monitor_pkg::*;

  logic                    rec_valid;
  logic                    rec_ready;
  logic [ISI_W-1:0]        rec_isi;
  logic signed [V_W-1:0]   rec_v;

  modport master (output rec_valid, output rec_isi, output rec_v, input  rec_ready);
  modport slave  (input  rec_valid, input  rec_isi, input  rec_v, output rec_ready);
endinterface

// File: rtl/spike_train_monitor_isi_fifo.sv
// Show-ahead synchronous FIFO for ISI records; accepts a push while full when a
// pop happens in the same cycle.
module spike_train_monitor_isi_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spike_train_monitor.sv
// Spike train monitor: onset detection, refractory lockout, ISI measurement
// into a record FIFO, and windowed firing-rate counting.
module spike_train_monitor
  import spike_train_monitor_pkg::*;
#(
  parameter int unsigned ISI_W       = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned REFRACT_CYC = 4,
  parameter int unsigned WINDOW      = 1024,
  parameter int unsigned RATE_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  spike_in,
  input  logic signed [V_W-1:0] v_in,
  spike_train_monitor_if.master rec,
  output logic [RATE_W-1:0]     rate_out,
  output logic                  rate_valid,
  output logic                  ovf
);

  localparam int unsigned REC_W = rec_w(ISI_W);
  localparam int unsigned RC_W  = $clog2(REFRACT_CYC + 1);
  localparam int unsigned WC_W  = $clog2(WINDOW);
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  typedef struct packed {
    logic [ISI_W-1:0]      isi;
    logic signed [V_W-1:0] v;
  } rec_t;

  state_t           state;
  logic             spike_q;
  logic [ISI_W-1:0] cnt;
  logic [RC_W-1:0]  rcnt;
  logic [WC_W-1:0]  wcnt;
  logic [RATE_W-1:0] scnt;

  logic             onset;
  logic             accept;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  logic [ISI_W-1:0] isi_next;
  rec_t             wr_rec;
  rec_t             rd_rec;

  assign onset    = spike_in & ~spike_q;
  assign accept   = onset & ((state == ST_WAIT_FIRST) | (state == ST_MEASURE)) & ~clr;
  assign push     = onset & (state == ST_MEASURE) & ~clr;
  assign pop      = ~empty & rec.rec_ready & ~clr;
  assign drop     = push & full & ~pop;
  // Saturating increment; also the ISI reported at an accepted onset.
  assign isi_next = (cnt == ISI_MAX) ? ISI_MAX : cnt + ISI_W'(1);
  assign wr_rec   = '{isi: isi_next, v: v_in};

  spike_train_monitor_isi_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (clr),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_rec),
    .rd_data (rd_rec),
    .full    (full),
    .empty   (empty)
  );

  assign rec.rec_valid = ~empty;
  assign rec.rec_isi   = rd_rec.isi;
  assign rec.rec_v     = rd_rec.v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_WAIT_FIRST;
      spike_q    <= 1'b0;
      cnt        <= '0;
      rcnt       <= '0;
      wcnt       <= '0;
      scnt       <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      spike_q    <= spike_in;
      rate_valid <= 1'b0;
      if (clr) begin
        state <= ST_WAIT_FIRST;
        cnt   <= '0;
        rcnt  <= '0;
        wcnt  <= '0;
        scnt  <= '0;
        ovf   <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_FIRST: begin
            if (onset) begin
              cnt   <= '0;
              rcnt  <= '0;
              state <= ST_REFRACT;
            end
          end
          ST_REFRACT: begin
            cnt  <= isi_next;
            rcnt <= rcnt + RC_W'(1);
            if (rcnt == RC_W'(REFRACT_CYC - 1)) state <= ST_MEASURE;
          end
          ST_MEASURE: begin
            if (onset) begin
              cnt   <= '0;
              rcnt  <= '0;
              state <= ST_REFRACT;
            end else begin
              cnt <= isi_next;
            end
          end
          default: state <= ST_WAIT_FIRST;
        endcase

        if (drop) ovf <= 1'b1;

        // Window close folds in an onset landing on the final cycle.
        if (wcnt == WC_W'(WINDOW - 1)) begin
          rate_out   <= scnt + RATE_W'(accept);
          rate_valid <= 1'b1;
          scnt       <= '0;
          wcnt       <= '0;
        end else begin
          wcnt <= wcnt + WC_W'(1);
          if (accept && (scnt != '1)) scnt <= scnt + RATE_W'(1);
        end
      end
    end
  end

endmodule
